// File: rtl/alu_pkg.sv
// Shared definitions for the word ALU sequencer and its nibble slice.
package alu_pkg;

  localparam int unsigned NIB = 4;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_SUB  = 3'b001;
  localparam op_t OP_ADC  = 3'b010;
  localparam op_t OP_SBC  = 3'b011;
  localparam op_t OP_AND  = 3'b100;
  localparam op_t OP_OR   = 3'b101;
  localparam op_t OP_XOR  = 3'b110;
  localparam op_t OP_NOTA = 3'b111;

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  // Arithmetic ops all live in the lower half of the encoding.
  function automatic logic is_arith(op_t op);
    return ~op[2];
  endfunction

  // Carry seeded into the least-significant nibble on an accepted start.
  function automatic logic init_carry(op_t op, logic cin);
    logic c;
    case (op)
      OP_ADD:         c = 1'b0;
      OP_SUB:         c = 1'b1;
      OP_ADC, OP_SBC: c = cin;
      default:        c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nib_alu.sv
// Combinational 4-bit ALU slice driven one nibble per cycle by the sequencer.
module nib_alu
  import alu_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  op_t            op,
  input  logic           ci,
  output logic [NIB-1:0] r,
  output logic           co,
  output logic           msb_ci
);

  logic [NIB-1:0] bx;
  logic [NIB:0]   sum;
  logic [NIB-1:0] low;

  // Subtract variants add the inverted B nibble; logic ops never carry.
  always_comb begin
    bx     = op[0] ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bx} + {{NIB{1'b0}}, ci};
    // Carry into the nibble MSB, used for signed overflow on the top nibble.
    low    = {1'b0, a[NIB-2:0]} + {1'b0, bx[NIB-2:0]} + {{(NIB-1){1'b0}}, ci};
    r      = '0;
    co     = 1'b0;
    msb_ci = 1'b0;
    if (is_arith(op)) begin
      r      = sum[NIB-1:0];
      co     = sum[NIB];
      msb_ci = low[NIB-1];
    end else begin
      case (op)
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        default: r = ~a;
      endcase
    end
  end

endmodule

// File: rtl/alu_word_sequencer.sv
// Multi-cycle word ALU: ripples a carry through a nibble slice, LS nibble first.
module alu_word_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic                   cin,
  input  logic [NIB*NIBBLES-1:0] a,
  input  logic [NIB*NIBBLES-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [NIB*NIBBLES-1:0] result,
  output logic                   cout,
  output logic                   zero,
  output logic                   ovf
);

  localparam int unsigned W    = NIB * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, result_q;
  op_t             op_q;
  logic            carry_q;
  logic [IdxW-1:0] idx_q;
  logic            busy_q, done_q, cout_q, zero_q, ovf_q;

  logic [NIB-1:0]  nib_a, nib_b, nib_r;
  logic            nib_co, nib_msb_ci;
  logic [W-1:0]    result_d;

  // Select the current operand nibbles and merge the new result nibble.
  always_comb begin
    nib_a    = a_q[idx_q * NIB +: NIB];
    nib_b    = b_q[idx_q * NIB +: NIB];
    result_d = result_q;
    result_d[idx_q * NIB +: NIB] = nib_r;
  end

  nib_alu u_nib_alu (
    .a      (nib_a),
    .b      (nib_b),
    .op     (op_q),
    .ci     (carry_q),
    .r      (nib_r),
    .co     (nib_co),
    .msb_ci (nib_msb_ci)
  );

  // Sequencer FSM with registered handshake, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= init_carry(op, cin);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= nib_co;
          if (idx_q == LastIdx) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= nib_co;
            zero_q  <= (result_d == '0);
            ovf_q   <= is_arith(op_q) & (nib_co ^ nib_msb_ci);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer with a word-level reference model.
module tb_alu_word_sequencer;
  import alu_pkg::*;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = OP_ADD;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, zero, ovf;
  logic [W-1:0] result;

  typedef struct {
    string        tag;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;

  alu_word_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .cin    (cin),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Word-level reference: whole-word add with explicit sign-based overflow.
  function automatic exp_t model(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input logic c);
    exp_t e;
    logic [W-1:0] bx;
    logic [W:0]   s;
    logic         c0;
    e.tag = tag;
    e.cout = 1'b0;
    e.ovf = 1'b0;
    bx = bv;
    c0 = 1'b0;
    case (o)
      OP_ADD: begin bx = bv;  c0 = 1'b0; end
      OP_SUB: begin bx = ~bv; c0 = 1'b1; end
      OP_ADC: begin bx = bv;  c0 = c;    end
      OP_SBC: begin bx = ~bv; c0 = c;    end
      default: ;
    endcase
    if (!o[2]) begin
      s = {1'b0, av} + {1'b0, bx} + {{W{1'b0}}, c0};
      e.result = s[W-1:0];
      e.cout = s[W];
      e.ovf = (av[W-1] == bx[W-1]) && (e.result[W-1] != av[W-1]);
    end else begin
      case (o)
        OP_AND:  e.result = av & bv;
        OP_OR:   e.result = av | bv;
        OP_XOR:  e.result = av ^ bv;
        default: e.result = ~av;
      endcase
    end
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_result"}, {16'b0, result}, {16'b0, e.result});
        chk({e.tag, "_cout"}, {31'b0, cout}, {31'b0, e.cout});
        chk({e.tag, "_zero"}, {31'b0, zero}, {31'b0, e.zero});
        chk({e.tag, "_ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic c);
    op = o; a = av; b = bv; cin = c; start = 1'b1;
  endtask

  // One operation; optionally re-pulse start with other operands at RUN cycle poke_at.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic c, input int poke_at);
    int lat = 0;
    int busy_n = 0;
    @(negedge clk);
    drive(o, av, bv, c);
    sb.push_back(model(tag, o, av, bv, c));
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == poke_at) drive(OP_XOR, 16'hFFFF, 16'h1234, 1'b1);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_busy_cycles"}, busy_n, 4);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int d0;
    int lat;

    // Reset state
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_result", {16'b0, result}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    chk("rst_zero", {31'b0, zero}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add1", OP_ADD, 16'h1234, 16'h0FFF, 1'b0, 0);
    run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 1'b0, 0);

    // Async reset after two nibbles: everything clears at once, no done follows
    @(negedge clk);
    drive(OP_ADD, 16'h7777, 16'h1111, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_result", {16'b0, result}, 0);
    chk("midrst_cout", {31'b0, cout}, 0);
    chk("midrst_zero", {31'b0, zero}, 0);
    chk("midrst_ovf", {31'b0, ovf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_seen - d0, 0);
    run_op("post_rst_add", OP_ADD, 16'h0001, 16'h0001, 1'b0, 0);

    run_op("sub_borrow", OP_SUB, 16'h0005, 16'h0007, 1'b0, 0);
    run_op("sbc_zero", OP_SBC, 16'h0005, 16'h0004, 1'b0, 0);
    run_op("xor", OP_XOR, 16'hA5A5, 16'hFFFF, 1'b0, 0);
    run_op("nota", OP_NOTA, 16'h00FF, 16'hFFFF, 1'b1, 0);
    run_op("adc_ovf", OP_ADC, 16'h7FFF, 16'h0000, 1'b1, 0);
    run_op("sbc_cin1", OP_SBC, 16'h1000, 16'h0001, 1'b1, 0);
    run_op("and", OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, 0);
    run_op("or", OP_OR, 16'h1200, 16'h0034, 1'b0, 0);

    // start mid-RUN is ignored: single done, first op's result
    d0 = done_seen;
    run_op("ignored_start", OP_ADD, 16'h0101, 16'h0202, 1'b0, 2);
    repeat (8) @(negedge clk);
    chk("ignored_start_done_count", done_seen - d0, 1);

    // start held through the done cycle: second op accepted back-to-back
    @(negedge clk);
    drive(OP_ADD, 16'h1111, 16'h2222, 1'b0);
    sb.push_back(model("b2b_first", OP_ADD, 16'h1111, 16'h2222, 1'b0));
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        drive(OP_SUB, 16'h0003, 16'h0009, 1'b0);
        sb.push_back(model("b2b_second", OP_SUB, 16'h0003, 16'h0009, 1'b0));
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("b2b_first_latency", lat, 5);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    chk("b2b_second_latency", lat, 5);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
